serial_addsub_engine: RTL and testbench
=======================================

// Module: serial_addsub_engine
// PURPOSE
//   Digit-serial adder/subtractor; successor to the fixed 16-bit bit-serial adder.
//   Width, digits per cycle and add/sub mode are parameters or run-time controls.
//   Adds start/busy/done handshake, carry-out and signed-overflow flags.
//   Sits between operand registers and the datapath result bus.
//   Trades area for latency: DIGIT bits are processed per clock.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of DIGIT
//   DIGIT   1  bits processed per clock (1 = bit-serial); 1 <= DIGIT <= WIDTH
//   NDIG   = WIDTH/DIGIT (localparam): digit cycles per operation
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; accepted only when busy==0
//   sub    in   1      0: a+b, 1: a-b; sampled with start
//   a      in   WIDTH  operand A; sampled with start
//   b      in   WIDTH  operand B; sampled with start
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle pulse; result outputs valid from this cycle
//   sum    out  WIDTH  result, held until the next done
//   cout   out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf    out  1      two's-complement overflow
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, count=0, carry=0, busy=0, done=0, sum=0, cout=0, ovf=0.
//   FSM:
//     IDLE -> RUN when start=1.
//       Capture a; capture b (inverted if sub); carry=sub; count=0.
//     RUN: each edge adds the low DIGIT bits of the A and B shift registers plus carry.
//       Shift the digit sum into the MSB end of the result shift register; update carry; count++.
//     RUN -> DONE on the edge where count==NDIG-1.
//       Same edge loads sum, cout=final carry, ovf=carry into MSB XOR carry out of MSB.
//     DONE -> IDLE unconditionally after one cycle; done=(state==DONE).
//   Latency: start sampled high in cycle 0 -> done high in cycle NDIG+1.
//     WIDTH=16, DIGIT=1: cycle 17. DIGIT=4: cycle 5.
//   Throughput: one op per NDIG+2 cycles; start may be held high for back-to-back ops.
//   start while busy (RUN or DONE): ignored. In-flight operands are unaffected; no queuing.
//   sub/a/b changing during RUN: no effect; operands are captured.
//   Arithmetic is modulo 2^WIDTH; sum is never saturated.
//   Reset mid-operation: aborts immediately; no done pulse; prior result is cleared to 0.
//   DIGIT==WIDTH: NDIG=1; one RUN cycle; done in cycle 2.
// STRUCTURE
//   Shared package serial_arith_pkg:
//     state encoding (IDLE, RUN, DONE)
//     clog2-based count width helper
//     WIDTH % DIGIT == 0 elaboration check
//   Sub-module digit_adder (DIGIT-bit ripple add):
//     inputs x, y, cin; outputs s, cout, c_into_msb
//     instantiated once.
//   Top: FSM, counter, three shift registers, result/flag registers.
// TESTING
//   Directed cases, WIDTH=16 and DIGIT=1 unless noted:
//   T1  a=0x0003, b=0x0001, sub=0 -> cycle 17: done=1 for one cycle, sum=0x0004, cout=0, ovf=0.
//   T2  a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0.
//       a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1.
//   T3  a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
//       a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
//   T4  DIGIT=4: a=0x1234, b=0x4321, sub=0 -> done in cycle 5, sum=0x5555.
//       DIGIT=16: done in cycle 2, same sum.
//   T5  pulse start again in cycle 3 with a=b=0xAAAA -> ignored; first result unchanged.
//       start held high -> next op accepted in the cycle after done.
//   T6  assert rst in cycle 8 of an op -> busy=0, sum=0 without waiting for a clock edge; no done.
//       New op after reset completes correctly.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial add/subtract engine:
// FSM state encoding, counter sizing and parameter legality helpers.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A one-digit operation still needs a 1-bit counter to exist.
  function automatic int count_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit digit_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder; also exposes the carry entering the top bit
// so the caller can form the two's-complement overflow flag.
module digit_adder #(
  parameter int D = 1
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         cin,
  output logic [D-1:0] s,
  output logic         cout,
  output logic         c_into_msb
);

  logic c;
  logic c_msb;

  always_comb begin
    c     = cin;
    c_msb = cin;
    s     = '0;
    for (int i = 0; i < D; i++) begin
      if (i == D - 1) c_msb = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout       = c;
    c_into_msb = c_msb;
  end

endmodule

// File: rtl/serial_addsub_engine.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, start/busy/done
// handshake, carry-out and signed-overflow flags.
module serial_addsub_engine
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = count_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (!digit_ok(WIDTH, DIGIT)) begin : g_param_check
      $error("serial_addsub_engine: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, r_sr_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, busy_q, done_q;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout, dig_cmsb;
  logic [WIDTH-1:0] a_sr_d, b_sr_d, r_sr_d;

  digit_adder #(.D(DIGIT)) u_digit_adder (
    .x          (a_sr_q[DIGIT-1:0]),
    .y          (b_sr_q[DIGIT-1:0]),
    .cin        (carry_q),
    .s          (dig_sum),
    .cout       (dig_cout),
    .c_into_msb (dig_cmsb)
  );

  // Result enters at the MSB end so that after NDIG digits it is aligned.
  always_comb begin
    a_sr_d = a_sr_q >> DIGIT;
    b_sr_d = b_sr_q >> DIGIT;
    r_sr_d = WIDTH'({dig_sum, r_sr_q} >> DIGIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1; the +1 rides in as the first carry.
            a_sr_q  <= a;
            b_sr_q  <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr_q  <= a_sr_d;
          b_sr_q  <= b_sr_d;
          r_sr_q  <= r_sr_d;
          carry_q <= dig_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q   <= r_sr_d;
            cout_q  <= dig_cout;
            ovf_q   <= dig_cmsb ^ dig_cout;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_engine.sv
// Bench for serial_addsub_engine: three instances (DIGIT 1, 4, 16) share one
// stimulus stream; directed table, random ops vs. a plain-arithmetic model.
module tb_serial_addsub_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub;
  logic [15:0] a, b;
  logic        busy_v[3], done_v[3], cout_v[3], ovf_v[3];
  logic [15:0] sum_v[3];

  int ndig_t[3] = '{16, 4, 1};
  int dig_t[3]  = '{1, 4, 16};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_addsub_engine #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_addsub_engine #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_addsub_engine #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: ordinary integer arithmetic, signed range test for overflow.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [16:0] t;
    int          r;
    logic        o;
    if (s) begin
      t = {1'b0, x} + 17'h10000 - {1'b0, y};
      r = int'($signed(x)) - int'($signed(y));
    end else begin
      t = {1'b0, x} + {1'b0, y};
      r = int'($signed(x)) + int'($signed(y));
    end
    o = (r > 32767) || (r < -32768);
    return {o, t[16], t[15:0]};
  endfunction

  task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic ts, input logic [15:0] es, input logic ec, input logic eo);
    int          lat[3];
    int          ndone[3];
    logic [15:0] s_c[3];
    logic        c_c[3], o_c[3];
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1; ndone[d] = 0; s_c[d] = '0; c_c[d] = 1'b0; o_c[d] = 1'b0;
    end
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      for (int d = 0; d < 3; d++) begin
        if (done_v[d]) begin
          ndone[d]++;
          if (lat[d] < 0) begin
            lat[d] = k; s_c[d] = sum_v[d]; c_c[d] = cout_v[d]; o_c[d] = ovf_v[d];
          end
        end
      end
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_D%0d_latency", name, dig_t[d]), 32'(lat[d]), 32'(ndig_t[d] + 1));
      chk($sformatf("%s_D%0d_done_pulses", name, dig_t[d]), 32'(ndone[d]), 32'd1);
      chk($sformatf("%s_D%0d_sum", name, dig_t[d]), 32'(s_c[d]), 32'(es));
      chk($sformatf("%s_D%0d_cout", name, dig_t[d]), 32'(c_c[d]), 32'(ec));
      chk($sformatf("%s_D%0d_ovf", name, dig_t[d]), 32'(o_c[d]), 32'(eo));
    end
    $display("[TB] %s a=%04h b=%04h sub=%0b -> sum=%04h cout=%0b ovf=%0b lat=%0d/%0d/%0d",
             name, ta, tb_, ts, s_c[0], c_c[0], o_c[0], lat[0], lat[1], lat[2]);
  endtask

  vec_t vecs[7];

  initial begin
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rs;
    int          lat[3];
    int          ndone[3];
    logic [15:0] s_c[3];
    int          dc[2][2];
    logic [15:0] ds[2][2];
    int          nd2[2];

    vecs[0] = '{"T1_add",      16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, 1'b0};
    vecs[1] = '{"T2_wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"T2_ovf",      16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"T3_borrow",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{"T3_ovf",      16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{"T4_digits",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6] = '{"zero_sub",    16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_D%0d_busy", dig_t[d]), 32'(busy_v[d]), 32'd0);
      chk($sformatf("reset_D%0d_done", dig_t[d]), 32'(done_v[d]), 32'd0);
      chk($sformatf("reset_D%0d_flags", dig_t[d]), {15'd0, cout_v[d], ovf_v[d], sum_v[d]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (i == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b0; end
      if (i == 1) begin ra = 16'h7FFF; rb = 16'h8000; rs = 1'b1; end
      m = model(ra, rb, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rs, m[15:0], m[16], m[17]);
    end

    // T5a: second start during RUN must be ignored by the multi-cycle instances.
    for (int d = 0; d < 3; d++) begin lat[d] = -1; ndone[d] = 0; s_c[d] = '0; end
    @(negedge clk);
    a = 16'h0003; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      for (int d = 0; d < 2; d++)
        if (done_v[d]) begin
          ndone[d]++;
          if (lat[d] < 0) begin lat[d] = k; s_c[d] = sum_v[d]; end
        end
      if (k == 3) begin a = 16'hAAAA; b = 16'hAAAA; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("T5_busy_start_D%0d_latency", dig_t[d]), 32'(lat[d]), 32'(ndig_t[d] + 1));
      chk($sformatf("T5_busy_start_D%0d_pulses", dig_t[d]), 32'(ndone[d]), 32'd1);
      chk($sformatf("T5_busy_start_D%0d_sum", dig_t[d]), 32'(s_c[d]), 32'h0004);
    end
    $display("[TB] T5_busy_start sum=%04h lat=%0d/%0d", s_c[0], lat[0], lat[1]);

    // T5b: start held high; operands change after first capture.
    for (int d = 0; d < 2; d++) begin
      nd2[d] = 0;
      for (int j = 0; j < 2; j++) begin dc[d][j] = -1; ds[d][j] = '0; end
    end
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; sub = 1'b0; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (done_v[d]) begin
          if (nd2[d] < 2) begin dc[d][nd2[d]] = k; ds[d][nd2[d]] = sum_v[d]; end
          nd2[d]++;
        end
      if (k == 1) begin a = 16'h0100; b = 16'h0020; end
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("T5_held_D%0d_first_cycle", dig_t[d]), 32'(dc[d][0]), 32'(ndig_t[d] + 1));
      chk($sformatf("T5_held_D%0d_first_sum", dig_t[d]), 32'(ds[d][0]), 32'h0003);
      chk($sformatf("T5_held_D%0d_second_cycle", dig_t[d]), 32'(dc[d][1]), 32'(2 * ndig_t[d] + 3));
      chk($sformatf("T5_held_D%0d_second_sum", dig_t[d]), 32'(ds[d][1]), 32'h0120);
    end
    $display("[TB] T5_held dones at %0d,%0d sums %04h,%04h", dc[0][0], dc[0][1], ds[0][0], ds[0][1]);

    // T6: asynchronous reset in cycle 8 of an operation.
    @(negedge clk);
    a = 16'h0003; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("T6_busy_before_rst", 32'(busy_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("T6_D%0d_busy_async", dig_t[d]), 32'(busy_v[d]), 32'd0);
      chk($sformatf("T6_D%0d_sum_async", dig_t[d]), 32'(sum_v[d]), 32'd0);
      chk($sformatf("T6_D%0d_done_async", dig_t[d]), 32'(done_v[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone[0] = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_v[0]) ndone[0]++;
      @(negedge clk);
    end
    chk("T6_no_done_after_abort", 32'(ndone[0]), 32'd0);
    $display("[TB] T6_reset_abort busy=%0b sum=%04h", busy_v[0], sum_v[0]);
    run_op("T6_after_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
